// File: rtl/sd_clk_pkg.sv
// SD clock generator shared types.
// State encoding and standard 27 MHz divisors.
package sd_clk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH
  } sd_state_e;

  localparam int SD_INIT_DIV_27M = 67;
  localparam int SD_FAST_DIV_27M = 0;

endpackage

// File: rtl/sd_clk_gen.sv
// SD card clock generator with glitch-free divisor switching.
// Emits rise/fall strobes for clkin-domain SD engines.
module sd_clk_gen
  import sd_clk_pkg::*;
#(
  parameter int DIV_W        = 8,
  parameter int INIT_DIV     = SD_INIT_DIV_27M,
  parameter bit STOP_ON_IDLE = 1'b1
) (
  input  logic             clkin,
  input  logic             reset_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_we,
  output logic             div_busy,
  output logic             sd_clk,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             running
);

  localparam logic [DIV_W-1:0] INIT_DIV_W =
    DIV_W'(INIT_DIV);

  sd_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_act_q, div_act_d;
  logic [DIV_W-1:0] div_pend_q, div_pend_d;
  logic             busy_q, busy_d;
  logic             sd_clk_q, sd_clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             go;

  assign go = en || !STOP_ON_IDLE;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    busy_d     = busy_q;
    sd_clk_d   = sd_clk_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;

    if (div_we) begin
      div_pend_d = div_i;
      busy_d     = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        sd_clk_d = 1'b0;
        if (go) begin
          state_d = ST_LOW;
          cnt_d   = div_act_q;
        end
      end
      ST_LOW: begin
        if (cnt_q == '0) begin
          if (go) begin
            state_d  = ST_HIGH;
            sd_clk_d = 1'b1;
            rise_d   = 1'b1;
            // New divisor only at a period start
            if (busy_q) begin
              div_act_d = div_pend_q;
              cnt_d     = div_pend_q;
              busy_d    = div_we;
            end else begin
              cnt_d = div_act_q;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HIGH: begin
        if (cnt_q == '0) begin
          state_d  = ST_LOW;
          sd_clk_d = 1'b0;
          fall_d   = 1'b1;
          cnt_d    = div_act_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      div_act_q  <= INIT_DIV_W;
      div_pend_q <= '0;
      busy_q     <= 1'b0;
      sd_clk_q   <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      busy_q     <= busy_d;
      sd_clk_q   <= sd_clk_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
    end
  end

  assign div_busy = busy_q;
  assign sd_clk   = sd_clk_q;
  assign rise_stb = rise_q;
  assign fall_stb = fall_q;
  assign running  = (state_q != ST_IDLE);

endmodule
